// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard sources in, stage enables out.
// slave = controller side, master = pipeline side.
interface pipeline_hazard_ctrl_if;
   logic        idex_mem_read;
   logic [4:0]  idex_rt;
   logic [4:0]  ifid_rs;
   logic [4:0]  ifid_rt;
   logic        exmem_mem_read;
   logic        exmem_mem_write;
   logic        exmem_branch;
   logic        exmem_zero;
   logic        dmem_ack;
   logic        pc_write;
   logic        ifid_write;
   logic        idex_stall;
   logic        exmem_stall;
   logic        ifid_flush;
   logic        idex_flush;
   logic        exmem_flush;
   logic        memwb_flush;
   logic        dmem_req;
   logic        branch_taken;
   logic [15:0] stall_count;
   logic        mem_timeout;

   modport slave (
      input  idex_mem_read, idex_rt, ifid_rs, ifid_rt,
      input  exmem_mem_read, exmem_mem_write,
      input  exmem_branch, exmem_zero, dmem_ack,
      output pc_write, ifid_write, idex_stall, exmem_stall,
      output ifid_flush, idex_flush, exmem_flush, memwb_flush,
      output dmem_req, branch_taken, stall_count, mem_timeout
   );

   modport master (
      output idex_mem_read, idex_rt, ifid_rs, ifid_rt,
      output exmem_mem_read, exmem_mem_write,
      output exmem_branch, exmem_zero, dmem_ack,
      input  pc_write, ifid_write, idex_stall, exmem_stall,
      input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
      input  dmem_req, branch_taken, stall_count, mem_timeout
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory wait > taken branch > load-use.
// Optional MEM_WAIT timeout enabled by macro PIPE_CTRL_TIMEOUT_EN.
module pipeline_hazard_ctrl (
   input  logic clk,
   input  logic reset,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam logic [1:0] S_RUN       = 2'd0;
   localparam logic [1:0] S_MEM_WAIT  = 2'd1;
   localparam logic [1:0] S_BR_SHADOW = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  w_nstate;
   logic [15:0] r_stall_cnt;
   logic        w_mem;
   logic        w_brt;
   logic        w_lu;
   logic        w_hold;
   logic        w_active;
   logic        w_to_hit;
   logic        w_to;
   logic        w_pc_write;
   logic        w_ifid_write;
   logic        w_idex_stall;
   logic        w_exmem_stall;
   logic        w_ifid_flush;
   logic        w_idex_flush;
   logic        w_exmem_flush;
   logic        w_memwb_flush;
   logic        w_dmem_req;
   logic        w_branch_taken;

   assign w_mem = hz.exmem_mem_read | hz.exmem_mem_write;
   assign w_brt = hz.exmem_branch & hz.exmem_zero;
   assign w_lu  = hz.idex_mem_read && (hz.idex_rt != 5'd0) &&
                  ((hz.idex_rt == hz.ifid_rs) ||
                   (hz.idex_rt == hz.ifid_rt));
   // MEM_WAIT holds until ack even if the request line drops.
   assign w_hold = !hz.dmem_ack &&
                   ((r_state == S_MEM_WAIT) ||
                    ((r_state == S_RUN) && w_mem));
   assign w_active = (r_state != S_BR_SHADOW);

   always_comb begin
      w_pc_write     = 1'b1;
      w_ifid_write   = 1'b1;
      w_idex_stall   = 1'b0;
      w_exmem_stall  = 1'b0;
      w_ifid_flush   = 1'b0;
      w_idex_flush   = 1'b0;
      w_exmem_flush  = 1'b0;
      w_memwb_flush  = 1'b0;
      w_dmem_req     = 1'b0;
      w_branch_taken = 1'b0;
      w_nstate       = S_RUN;
      if (!reset) begin
         w_dmem_req = w_active & w_mem;
         if (w_hold) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
            w_memwb_flush = 1'b1;
            w_nstate      = w_to_hit ? S_RUN : S_MEM_WAIT;
         end else if (w_active && w_brt) begin
            w_branch_taken = 1'b1;
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_exmem_flush  = 1'b1;
            w_nstate       = S_BR_SHADOW;
         end else if (w_active && w_lu) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_RUN;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state <= w_nstate;
         if (!w_pc_write && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

`ifdef PIPE_CTRL_TIMEOUT_EN
   logic [7:0] r_wcnt;
   logic       r_to;

   // Counter sits at 0 outside MEM_WAIT, so entry starts a fresh count.
   assign w_to_hit = (r_state == S_MEM_WAIT) && !hz.dmem_ack &&
                     (r_wcnt == 8'd254);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wcnt <= 8'd0;
         r_to   <= 1'b0;
      end else begin
         if (r_state != S_MEM_WAIT || hz.dmem_ack || w_to_hit)
            r_wcnt <= 8'd0;
         else
            r_wcnt <= r_wcnt + 8'd1;
         if (w_to_hit)
            r_to <= 1'b1;
      end
   end
   assign w_to = r_to;
`else
   assign w_to_hit = 1'b0;
   assign w_to     = 1'b0;
`endif

   assign hz.pc_write     = w_pc_write;
   assign hz.ifid_write   = w_ifid_write;
   assign hz.idex_stall   = w_idex_stall;
   assign hz.exmem_stall  = w_exmem_stall;
   assign hz.ifid_flush   = w_ifid_flush;
   assign hz.idex_flush   = w_idex_flush;
   assign hz.exmem_flush  = w_exmem_flush;
   assign hz.memwb_flush  = w_memwb_flush;
   assign hz.dmem_req     = w_dmem_req;
   assign hz.branch_taken = w_branch_taken;
   assign hz.stall_count  = r_stall_cnt;
   assign hz.mem_timeout  = w_to;
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 idex_mem_read  in  1  instruction in EX is a load.
REQ-004 idex_rt  in  5  load destination register in EX.
REQ-005 ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID.
REQ-006 exmem_mem_read, exmem_mem_write  in  1 each  MEM-stage load/store active.
REQ-007 exmem_branch, exmem_zero  in  1 each  MEM-stage branch and ALU zero flag.
REQ-008 dmem_ack  in  1  data memory completes the requested access this cycle.
REQ-009 pc_write, ifid_write  out  1 each  PC / IF-ID register update enable.
REQ-010 idex_stall, exmem_stall  out  1 each  hold ID-EX / EX-MEM pipeline registers.
REQ-011 ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (zero control) into that register.
REQ-012 dmem_req  out  1  data memory request.
REQ-013 branch_taken  out  1  PC selects pc_branch.
REQ-014 stall_count  out  16  cycles with pc_write=0 since reset.
REQ-015 mem_timeout  out  1  sticky memory-timeout flag (see Configuration).

Function
REQ-016 FSM states: RUN, MEM_WAIT, BR_SHADOW; outputs combinational from state and inputs.
REQ-017 Default (no hazard): pc_write=ifid_write=1; all stall/flush/branch_taken=0.
REQ-018 dmem_req = exmem_mem_read | exmem_mem_write in RUN and MEM_WAIT.
REQ-019 Priority in RUN: memory wait > branch taken > load-use.
REQ-020 Memory wait: RUN with dmem_req=1 and dmem_ack=0 -> MEM_WAIT; same cycle pc_write=ifid_write=0, idex_stall=exmem_stall=1, memwb_flush=1.
REQ-021 MEM_WAIT holds those outputs until dmem_ack=1; ack cycle releases all stalls and returns to RUN, branch evaluated in that cycle per REQ-022.
REQ-022 Branch: exmem_branch & exmem_zero with no memory wait -> branch_taken=1, ifid_flush=idex_flush=exmem_flush=1, pc_write=1; next state BR_SHADOW.
REQ-023 BR_SHADOW lasts exactly 1 cycle; load-use detection suppressed; -> RUN.
REQ-024 Load-use: idex_mem_read=1, idex_rt!=0, idex_rt equals ifid_rs or ifid_rt -> pc_write=ifid_write=0, idex_flush=1 for that cycle only; no state change.
REQ-025 Zero-latency ack (dmem_ack=1 while in RUN) causes no stall.
REQ-026 stall_count increments each cycle pc_write=0; saturates at 16'hFFFF.

Reset
REQ-027 reset forces state RUN, stall_count=0, mem_timeout=0, any cycle including mid-MEM_WAIT.
REQ-028 While reset asserted, outputs equal RUN with all inputs 0: pc_write=ifid_write=1, all others 0.

Configuration
REQ-029 Macro PIPE_CTRL_TIMEOUT_EN defined: 8-bit wait counter cleared on MEM_WAIT entry; 255th consecutive MEM_WAIT cycle without ack sets mem_timeout (sticky until reset) and forces RUN next cycle.
REQ-030 Macro undefined: no counter, mem_timeout tied 0, MEM_WAIT waits indefinitely.

Verification
REQ-031 idex_mem_read=1, idex_rt=5, ifid_rs=5 -> one cycle pc_write=0, idex_flush=1, stall_count=1.
REQ-032 Same with idex_rt=0 -> no stall, stall_count stays 0.
REQ-033 exmem_mem_read=1, dmem_ack low 3 cycles then high -> exmem_stall=1 for 3 cycles, release on ack cycle, stall_count=3.
REQ-034 exmem_branch=exmem_zero=1 with load-use pattern in next cycle -> branch_taken and 3 flushes for 1 cycle, no load-use stall in BR_SHADOW.
REQ-035 reset pulsed mid-MEM_WAIT -> state RUN, stall_count=0, exmem_stall=0 immediately.
REQ-036 With PIPE_CTRL_TIMEOUT_EN, store with dmem_ack never high -> mem_timeout=1 after 255 wait cycles, return to RUN.
